qpsk_demod: RTL and testbench



---
 rtl/qpsk_demod.sv | 114 +++++++++++
 tb/tb_qpsk_demod.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_demod.sv
`default_nettype none
// ============================================================================
// Module      : qpsk_demod
// Description : QPSK integrate-and-dump hard-decision demodulator; packs 16
//               decided symbols per 32-bit AXI-Stream word.
//               Optional framing via macro QPSK_DEMOD_TLAST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module qpsk_demod #(
    parameter int SPS   = 4,
    parameter int ACC_W = 16 + $clog2(SPS)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_tdata,
    input  logic        in_tvalid,
    output logic        in_tready,
`ifdef QPSK_DEMOD_TLAST_EN
    input  logic        in_tlast,
    output logic        out_tlast,
`endif
    output logic [31:0] out_tdata,
    output logic        out_tvalid,
    input  logic        out_tready
);

    localparam int              CNT_W         = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [CNT_W-1:0] C_LAST_SAMPLE = CNT_W'(SPS - 1);

    logic signed [ACC_W-1:0] r_acc_i;
    logic signed [ACC_W-1:0] r_acc_q;
    logic signed [ACC_W-1:0] w_sum_i;
    logic signed [ACC_W-1:0] w_sum_q;
    logic [CNT_W-1:0]        r_scnt;
    logic [3:0]              r_kcnt;
    logic [31:0]             r_word;
    logic [31:0]             w_word_next;
    logic [31:0]             w_emit_word;
    logic                    w_xfer;
    logic                    w_sym_done;
    logic                    w_word_done;
    logic                    w_end_frame;
    logic                    w_emit;

    assign in_tready   = ~out_tvalid | out_tready;
    assign w_xfer      = in_tvalid & in_tready;
    assign w_sum_i     = r_acc_i + ACC_W'($signed(in_tdata[15:0]));
    assign w_sum_q     = r_acc_q + ACC_W'($signed(in_tdata[31:16]));
    assign w_sym_done  = w_xfer & (r_scnt == C_LAST_SAMPLE);
    assign w_word_done = w_sym_done & (r_kcnt == 4'd15);

`ifdef QPSK_DEMOD_TLAST_EN
    assign w_end_frame = w_xfer & in_tlast;
`else
    assign w_end_frame = 1'b0;
`endif
    assign w_emit = w_word_done | w_end_frame;

    // Sign bits are the decisions: a zero sum decides as positive (bit 0).
    always_comb begin
        w_word_next                     = r_word;
        w_word_next[{r_kcnt, 1'b0} +: 2] = {w_sum_q[ACC_W-1], w_sum_i[ACC_W-1]};
        w_emit_word                     = w_sym_done ? w_word_next : r_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc_i    <= '0;
            r_acc_q    <= '0;
            r_scnt     <= '0;
            r_kcnt     <= '0;
            r_word     <= '0;
            out_tdata  <= '0;
            out_tvalid <= 1'b0;
`ifdef QPSK_DEMOD_TLAST_EN
            out_tlast  <= 1'b0;
`endif
        end else begin
            // A new word may only arrive while in_tready=1, so it safely
            // overwrites an old word that is being drained this cycle.
            if (w_emit) begin
                out_tdata  <= w_emit_word;
                out_tvalid <= 1'b1;
`ifdef QPSK_DEMOD_TLAST_EN
                out_tlast  <= w_end_frame;
`endif
            end else if (out_tready) begin
                out_tvalid <= 1'b0;
            end

            if (w_xfer) begin
                if (w_end_frame) begin
                    r_acc_i <= '0;
                    r_acc_q <= '0;
                    r_scnt  <= '0;
                    r_kcnt  <= '0;
                    r_word  <= '0;
                end else if (w_sym_done) begin
                    r_acc_i <= '0;
                    r_acc_q <= '0;
                    r_scnt  <= '0;
                    r_kcnt  <= r_kcnt + 4'd1;
                    r_word  <= w_word_done ? 32'd0 : w_word_next;
                end else begin
                    r_acc_i <= w_sum_i;
                    r_acc_q <= w_sum_q;
                    r_scnt  <= r_scnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qpsk_demod.sv
`default_nettype none
// ============================================================================
// Module      : tb_qpsk_demod
// Description : Scoreboard bench for qpsk_demod (SPS=4); framing scenario
//               runs when QPSK_DEMOD_TLAST_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qpsk_demod;

    localparam int          SPS = 4;
    localparam logic [15:0] P   = 16'h6665;
    localparam logic [15:0] N   = 16'h999B;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_tdata;
    logic        in_tvalid;
    logic        in_tready;
    logic [31:0] out_tdata;
    logic        out_tvalid;
    logic        out_tready;
`ifdef QPSK_DEMOD_TLAST_EN
    logic        in_tlast;
    logic        out_tlast;
`endif

    int          checks   = 0;
    int          failures = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    qpsk_demod #(.SPS(SPS)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_tdata   (in_tdata),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
`ifdef QPSK_DEMOD_TLAST_EN
        .in_tlast   (in_tlast),
        .out_tlast  (out_tlast),
`endif
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready)
    );

    // Scoreboard: every accepted output word is compared with the queue head.
    always @(negedge clk) begin
        if (!reset && out_tvalid && out_tready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_word got=%h expected=none", out_tdata);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if (out_tdata !== e[31:0]) begin
                    failures++;
                    $display("FAIL word_data got=%h expected=%h", out_tdata, e[31:0]);
                end
`ifdef QPSK_DEMOD_TLAST_EN
                else if (out_tlast !== e[32]) begin
                    failures++;
                    $display("FAIL word_tlast got=%b expected=%b", out_tlast, e[32]);
                end
`endif
            end
        end
    end

    task automatic send(input logic [15:0] i, input logic [15:0] q, input logic last);
        int  n;
        bit  done;
        n    = 0;
        done = 0;
        in_tdata  = {q, i};
        in_tvalid = 1'b1;
`ifdef QPSK_DEMOD_TLAST_EN
        in_tlast  = last;
`else
        if (last) $display("note: framing disabled, last ignored");
`endif
        while (!done) begin
            @(negedge clk);
            if (in_tready) done = 1;
            else if (++n > 2000) begin
                checks++;
                failures++;
                $display("FAIL send_timeout got=stalled expected=in_tready");
                in_tvalid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input logic [1:0] s);
        for (int k = 0; k < SPS; k++) send(s[0] ? N : P, s[1] ? N : P, 1'b0);
    endtask

    task automatic idle();
        in_tvalid = 1'b0;
`ifdef QPSK_DEMOD_TLAST_EN
        in_tlast  = 1'b0;
`endif
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d_pending expected=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        out_tready = 1'b1;
        in_tdata   = '0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (out_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b expected=0", out_tvalid); end
        checks++;
        if (out_tdata !== 32'd0) begin failures++; $display("FAIL reset_tdata got=%h expected=0", out_tdata); end
        checks++;
        if (in_tready !== 1'b1) begin failures++; $display("FAIL reset_tready got=%b expected=1", in_tready); end
    endtask

    task automatic test_latency();
        exp_q.push_back({1'b0, 32'h0000_0000});
        for (int n = 0; n < 63; n++) send(P, P, 1'b0);
        checks++;
        if (out_tvalid !== 1'b0) begin failures++; $display("FAIL early_tvalid got=%b expected=0", out_tvalid); end
        send(P, P, 1'b0);
        idle();
        checks++;
        if (out_tvalid !== 1'b1) begin failures++; $display("FAIL latency_tvalid got=%b expected=1", out_tvalid); end
        wait_drain();
    endtask

    task automatic test_patterns();
        exp_q.push_back({1'b0, 32'hE4E4_E4E4});
        exp_q.push_back({1'b0, 32'h1B1B_1B1B});
        for (int r = 0; r < 4; r++)
            for (int s = 0; s < 4; s++) send_sym(2'(s));
        for (int r = 0; r < 4; r++)
            for (int s = 3; s >= 0; s--) send_sym(2'(s));
        idle();
        wait_drain();
    endtask

    task automatic test_noisy();
        // k0: I sum +10, k1: I sum 0, k2: I = 4x -32768, k3: Q = 4x -32768
        exp_q.push_back({1'b0, 32'h0000_0090});
        send(16'd100, P, 1'b0); send(16'hFFCE, P, 1'b0);
        send(16'hFFCE, P, 1'b0); send(16'd10, P, 1'b0);
        send(16'd50, P, 1'b0); send(16'hFFCE, P, 1'b0);
        send(16'd50, P, 1'b0); send(16'hFFCE, P, 1'b0);
        for (int n = 0; n < SPS; n++) send(16'h8000, P, 1'b0);
        for (int n = 0; n < SPS; n++) send(16'h7FFF, 16'h8000, 1'b0);
        for (int s = 0; s < 12; s++) send_sym(2'b00);
        idle();
        wait_drain();
    endtask

    task automatic test_back_to_back();
        out_tready = 1'b0;
        exp_q.push_back({1'b0, 32'hFFFF_FFFF});
        exp_q.push_back({1'b0, 32'hE4E4_E4E4});
        fork
            begin
                for (int s = 0; s < 16; s++) send_sym(2'b11);
                for (int r = 0; r < 4; r++)
                    for (int s = 0; s < 4; s++) send_sym(2'(s));
                idle();
            end
            begin
                int n;
                n = 0;
                while (!out_tvalid && n < 3000) begin @(negedge clk); n++; end
                checks++;
                if (!out_tvalid) begin failures++; $display("FAIL stall_wait got=0 expected=1"); end
                for (int c = 0; c < 8; c++) begin
                    @(negedge clk);
                    checks++;
                    if (in_tready !== 1'b0 || out_tdata !== 32'hFFFF_FFFF) begin
                        failures++;
                        $display("FAIL stall_hold got=ready%b/%h expected=ready0/ffffffff", in_tready, out_tdata);
                    end
                end
                @(posedge clk);
                #1;
                out_tready = 1'b1;
            end
        join
        wait_drain();
    endtask

    task automatic test_reset_mid();
        out_tready = 1'b0;
        for (int s = 0; s < 16; s++) send_sym(2'b11);
        idle();
        checks++;
        if (out_tvalid !== 1'b1) begin failures++; $display("FAIL pending_tvalid got=%b expected=1", out_tvalid); end
        pulse_reset();
        checks++;
        if (out_tvalid !== 1'b0 || out_tdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_pending got=%b/%h expected=0/00000000", out_tvalid, out_tdata);
        end
        out_tready = 1'b1;
        for (int n = 0; n < 37; n++) send(P, P, 1'b0);
        idle();
        pulse_reset();
        checks++;
        if (out_tvalid !== 1'b0) begin failures++; $display("FAIL reset_partial got=%b expected=0", out_tvalid); end
        exp_q.push_back({1'b0, 32'hFFFF_FFFF});
        for (int s = 0; s < 16; s++) send_sym(2'b11);
        idle();
        wait_drain();
    endtask

`ifdef QPSK_DEMOD_TLAST_EN
    task automatic test_tlast();
        out_tready = 1'b1;
        exp_q.push_back({1'b1, 32'h0000_0015});
        exp_q.push_back({1'b0, 32'hE4E4_E4E4});
        for (int s = 0; s < 3; s++) send_sym(2'b01);
        send(P, P, 1'b0);
        send(P, P, 1'b1);
        for (int r = 0; r < 4; r++)
            for (int s = 0; s < 4; s++) send_sym(2'(s));
        idle();
        wait_drain();
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_patterns();
        test_noisy();
        test_back_to_back();
        test_reset_mid();
`ifdef QPSK_DEMOD_TLAST_EN
        test_tlast();
`endif
        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
